sal_rw_sched: RTL and testbench
===============================

SAL_RW_SCHED -- requirements
Module: sal_rw_sched

Interface
REQ-001 Parameter NUM_BANKS, default 4, number of bank requesters (2..8).
REQ-002 Parameter STARVE_LIMIT, default 8, consecutive same-direction grants allowed while the opposite direction waits (1..15).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 rd_req  in  NUM_BANKS  per-bank column-read request; held until granted.
REQ-006 wr_req  in  NUM_BANKS  per-bank column-write request; held until granted.
REQ-007 t_ccd  in  4  minimum cycles between column grants; 0 treated as 1.
REQ-008 t_rtw  in  4  read-to-write turnaround cycles.
REQ-009 t_wtr  in  4  write-to-read turnaround cycles.
REQ-010 rd_gnt  out  NUM_BANKS  one-hot read grant, one-cycle pulse.
REQ-011 wr_gnt  out  NUM_BANKS  one-hot write grant, one-cycle pulse.
REQ-012 cur_dir  out  1  registered direction: 0 read (RD, W2R), 1 write (WR, R2W).

Function
REQ-013 Grants SHALL be combinational from registered state and live requests (zero latency); requester drops its request the cycle after the grant.
REQ-014 At most one bit of {rd_gnt, wr_gnt} SHALL be set in any cycle.
REQ-015 FSM states RD, WR, R2W, W2R; reset state RD.
REQ-016 RD: read grant issued when any rd_req, ccd_cnt==0 and starve_cnt<STARVE_LIMIT; bank chosen round-robin starting after last-granted read bank.
REQ-017 RD -> R2W when any wr_req and (no rd_req or starve_cnt==STARVE_LIMIT); no grant that cycle; turn_cnt loaded with t_rtw.
REQ-018 WR: mirror of REQ-016/017 with wr_req, write pointer, transition WR -> W2R loading t_wtr.
REQ-019 R2W/W2R: no grants; if turn_cnt==0 move to WR/RD, else decrement (turnaround occupies t_rtw+1 / t_wtr+1 cycles).
REQ-020 ccd_cnt SHALL load max(t_ccd,1)-1 on every grant and decrement to 0 otherwise, continuing through turnaround states.
REQ-021 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each grant while any opposite-direction request is asserted, clear on grant with no opposite request, clear on entering R2W/W2R.
REQ-022 Simultaneous rd_req and wr_req without starvation: current direction wins.
REQ-023 No requests: state and pointers hold; ccd_cnt continues counting.
REQ-024 Round-robin pointers (read and write independent) SHALL advance only on a grant in their direction; pointer wraps NUM_BANKS-1 -> 0.
REQ-025 Timing inputs SHALL be sampled when loaded; changes mid-turnaround do not affect the running count.

Reset
REQ-026 While rst is high: rd_gnt=0, wr_gnt=0, cur_dir=0, state=RD, ccd_cnt=0, turn_cnt=0, starve_cnt=0, both pointers=0 (bank 0 highest priority).
REQ-027 rst asserted mid-turnaround SHALL abort it; first post-reset cycle may grant a read.

Configuration
REQ-028 With SAL_RW_SCHED_STAT_EN defined, outputs rd_gnt_cnt and wr_gnt_cnt (16-bit, wrapping, cleared by rst) SHALL count issued grants.
REQ-029 Without SAL_RW_SCHED_STAT_EN these ports and counters SHALL not exist; other behaviour identical.

Verification
REQ-030 Post-reset, rd_req=4'b1111 held, t_ccd=2 -> rd_gnt 0001,0000,0010,0000,0100,0000,1000 on consecutive cycles.
REQ-031 RD with no rd_req, wr_req[2]=1, t_rtw=3 -> cur_dir=1 next cycle, wr_gnt=0100 exactly 5 cycles after wr_req rises.
REQ-032 rd_req=0001 continuous, wr_req=0010 asserted, STARVE_LIMIT=8, t_ccd=1 -> exactly 8 read grants then R2W, then wr_gnt=0010.
REQ-033 t_ccd=0 with continuous reads -> read grant every cycle; never two grant bits in one cycle.
REQ-034 rst pulsed during W2R with t_wtr=10 -> all counters 0, state RD, read granted cycle after rst falls.
REQ-035 With SAL_RW_SCHED_STAT_EN, 70000 read grants -> rd_gnt_cnt=4464 (wrapped).

Source files
------------

// File: rtl/sal_rw_sched.sv
// sal_rw_sched: column read/write grant scheduler for a multi-bank memory.
// Round-robin arbitration inside each direction. Direction changes go through
// a turnaround state, and a starvation limit forces the scheduler toward the
// waiting direction.
// Optional build macro SAL_RW_SCHED_STAT_EN adds the 16-bit grant counters
// rd_gnt_cnt and wr_gnt_cnt.
//
// state | meaning
// ------+---------------------------------------------------------------
// RD    | read direction; issues read grants
// WR    | write direction; issues write grants
// R2W   | read-to-write turnaround; no grants; counts turn_cnt down to 0
// W2R   | write-to-read turnaround; no grants; counts turn_cnt down to 0
module sal_rw_sched #(
  parameter int NUM_BANKS    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BANKS-1:0] rd_req,
  input  logic [NUM_BANKS-1:0] wr_req,
  input  logic [3:0]           t_ccd,
  input  logic [3:0]           t_rtw,
  input  logic [3:0]           t_wtr,
  output logic [NUM_BANKS-1:0] rd_gnt,
  output logic [NUM_BANKS-1:0] wr_gnt,
  output logic                 cur_dir
`ifdef SAL_RW_SCHED_STAT_EN
  ,
  output logic [15:0]          rd_gnt_cnt,
  output logic [15:0]          wr_gnt_cnt
`endif
);

  localparam int PW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);
  localparam logic [NUM_BANKS-1:0] ONE = NUM_BANKS'(1);

  typedef enum logic [1:0] {S_RD, S_WR, S_R2W, S_W2R} state_t;

  state_t        state, state_nxt;
  logic [3:0]    ccd_cnt, ccd_nxt;
  logic [3:0]    turn_cnt, turn_nxt;
  logic [3:0]    starve_cnt, starve_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] rd_sel, wr_sel;
  logic [3:0]    ccd_load;
  logic          any_rd, any_wr;
  logic          rd_go, wr_go;

  // The pointer marks the highest-priority bank; the search starts there.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                            input logic [PW-1:0] ptr);
    logic found;
    int   idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      idx = (int'(ptr) + i) % NUM_BANKS;
      if (!found && req[idx]) begin
        rr_pick = PW'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  // After a grant, the bank after the granted one gets highest priority.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] sel);
    ptr_inc = (sel == PW'(NUM_BANKS - 1)) ? '0 : sel + 1'b1;
  endfunction

  assign any_rd   = |rd_req;
  assign any_wr   = |wr_req;
  assign rd_sel   = rr_pick(rd_req, rd_ptr);
  assign wr_sel   = rr_pick(wr_req, wr_ptr);
  assign ccd_load = (t_ccd == 4'd0) ? 4'd0 : t_ccd - 4'd1;

  // Next-state, counter updates and grant decisions.
  always_comb begin
    state_nxt  = state;
    turn_nxt   = turn_cnt;
    starve_nxt = starve_cnt;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    ccd_nxt    = (ccd_cnt != 4'd0) ? ccd_cnt - 4'd1 : ccd_cnt;
    rd_go      = 1'b0;
    wr_go      = 1'b0;
    case (state)
      S_RD: begin
        if (any_wr && (!any_rd || starve_cnt == SLIM)) begin
          state_nxt  = S_R2W;
          turn_nxt   = t_rtw;
          starve_nxt = 4'd0;
        end else if (any_rd && ccd_cnt == 4'd0 && starve_cnt < SLIM) begin
          rd_go      = 1'b1;
          ccd_nxt    = ccd_load;
          rd_ptr_nxt = ptr_inc(rd_sel);
          starve_nxt = any_wr ? starve_cnt + 4'd1 : 4'd0;
        end
      end
      S_WR: begin
        if (any_rd && (!any_wr || starve_cnt == SLIM)) begin
          state_nxt  = S_W2R;
          turn_nxt   = t_wtr;
          starve_nxt = 4'd0;
        end else if (any_wr && ccd_cnt == 4'd0 && starve_cnt < SLIM) begin
          wr_go      = 1'b1;
          ccd_nxt    = ccd_load;
          wr_ptr_nxt = ptr_inc(wr_sel);
          starve_nxt = any_rd ? starve_cnt + 4'd1 : 4'd0;
        end
      end
      S_R2W: begin
        if (turn_cnt == 4'd0) state_nxt = S_WR;
        else                  turn_nxt  = turn_cnt - 4'd1;
      end
      S_W2R: begin
        if (turn_cnt == 4'd0) state_nxt = S_RD;
        else                  turn_nxt  = turn_cnt - 4'd1;
      end
      default: state_nxt = S_RD;
    endcase
  end

  // Grants are suppressed while reset is held, even though the decision is live.
  assign rd_gnt  = (rd_go && !rst) ? (ONE << rd_sel) : '0;
  assign wr_gnt  = (wr_go && !rst) ? (ONE << wr_sel) : '0;
  assign cur_dir = (state == S_WR) || (state == S_R2W);

  // State and counter registers; reset aborts any running turnaround.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RD;
      ccd_cnt    <= 4'd0;
      turn_cnt   <= 4'd0;
      starve_cnt <= 4'd0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      state      <= state_nxt;
      ccd_cnt    <= ccd_nxt;
      turn_cnt   <= turn_nxt;
      starve_cnt <= starve_nxt;
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
    end
  end

`ifdef SAL_RW_SCHED_STAT_EN
  // Free-running, wrapping grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_gnt_cnt <= 16'd0;
      wr_gnt_cnt <= 16'd0;
    end else begin
      if (rd_go) rd_gnt_cnt <= rd_gnt_cnt + 16'd1;
      if (wr_go) wr_gnt_cnt <= wr_gnt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sal_rw_sched.sv
// Bench for sal_rw_sched (default parameters). It uses a directed vector table
// plus hand-written sequences for starvation, t_ccd=0 and reset during
// turnaround. The counter test runs when SAL_RW_SCHED_STAT_EN is defined.
module tb_sal_rw_sched;

  logic       clk;
  logic       rst;
  logic [3:0] rd_req, wr_req;
  logic [3:0] t_ccd, t_rtw, t_wtr;
  logic [3:0] rd_gnt, wr_gnt;
  logic       cur_dir;
`ifdef SAL_RW_SCHED_STAT_EN
  logic [15:0] rd_gnt_cnt, wr_gnt_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  sal_rw_sched #(.NUM_BANKS(4), .STARVE_LIMIT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_req  (rd_req),
    .wr_req  (wr_req),
    .t_ccd   (t_ccd),
    .t_rtw   (t_rtw),
    .t_wtr   (t_wtr),
    .rd_gnt  (rd_gnt),
    .wr_gnt  (wr_gnt),
    .cur_dir (cur_dir)
`ifdef SAL_RW_SCHED_STAT_EN
    ,
    .rd_gnt_cnt (rd_gnt_cnt),
    .wr_gnt_cnt (wr_gnt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] rd;
    logic [3:0] wr;
    logic [3:0] erd;
    logic [3:0] ewr;
    logic       edir;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic step(input logic r, input logic [3:0] rd, input logic [3:0] wr,
                      input logic [3:0] cc, input logic [3:0] rtw, input logic [3:0] wtr);
    @(posedge clk);
    #1;
    rst = r; rd_req = rd; wr_req = wr; t_ccd = cc; t_rtw = rtw; t_wtr = wtr;
    @(negedge clk);
  endtask

  initial begin
    int         nrd;
    int         wr_cyc;
    int         wr_val;
    logic       wr_pend;
    logic [3:0] e;

    rst = 1'b1; rd_req = '0; wr_req = '0; t_ccd = 4'd2; t_rtw = 4'd3; t_wtr = 4'd1;

    // rst, rd, wr, exp rd_gnt, exp wr_gnt, exp cur_dir (t_ccd=2, t_rtw=3, t_wtr=1)
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 4'h0, 4'h1, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 4'hF, 4'h0, 4'h2, 4'h0, 1'b0};
    tbl[4]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[5]  = '{1'b0, 4'hF, 4'h0, 4'h4, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 4'hF, 4'h0, 4'h8, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[9]  = '{1'b0, 4'hF, 4'h0, 4'h1, 4'h0, 1'b0};
    tbl[10] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 4'h4, 4'h0, 4'h0, 1'b0};
    tbl[12] = '{1'b0, 4'h0, 4'h4, 4'h0, 4'h0, 1'b1};
    tbl[13] = '{1'b0, 4'h0, 4'h4, 4'h0, 4'h0, 1'b1};
    tbl[14] = '{1'b0, 4'h0, 4'h4, 4'h0, 4'h0, 1'b1};
    tbl[15] = '{1'b0, 4'h0, 4'h4, 4'h0, 4'h0, 1'b1};
    tbl[16] = '{1'b0, 4'h0, 4'h4, 4'h0, 4'h4, 1'b1};
    tbl[17] = '{1'b0, 4'h1, 4'h9, 4'h0, 4'h0, 1'b1};
    tbl[18] = '{1'b0, 4'h1, 4'h9, 4'h0, 4'h8, 1'b1};
    tbl[19] = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1};
    tbl[20] = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h1, 1'b1};
    tbl[21] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[22] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[23] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[24] = '{1'b0, 4'h1, 4'h0, 4'h1, 4'h0, 1'b0};
    tbl[25] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].rst, tbl[i].rd, tbl[i].wr, 4'd2, 4'd3, 4'd1);
      chk($sformatf("vec%0d rd_gnt", i), int'(rd_gnt), int'(tbl[i].erd));
      chk($sformatf("vec%0d wr_gnt", i), int'(wr_gnt), int'(tbl[i].ewr));
      chk($sformatf("vec%0d cur_dir", i), int'(cur_dir), int'(tbl[i].edir));
    end

    // Starvation: 8 reads while a write waits, then R2W (t_rtw=2), then the write.
    step(1'b1, 4'h0, 4'h0, 4'd1, 4'd2, 4'd1);
    nrd = 0; wr_cyc = -1; wr_val = 0; wr_pend = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 4'h1, wr_pend ? 4'h2 : 4'h0, 4'd1, 4'd2, 4'd1);
      if (wr_pend && rd_gnt != 4'h0) nrd++;
      if (wr_pend && wr_gnt != 4'h0) begin
        wr_cyc = c; wr_val = int'(wr_gnt); wr_pend = 1'b0;
      end
    end
    chk("starve read count", nrd, 8);
    chk("starve write cycle", wr_cyc, 12);
    chk("starve write grant", wr_val, 2);

    // t_ccd=0: a read grant every cycle in round-robin order, never two bits.
    step(1'b1, 4'h0, 4'h0, 4'd0, 4'd1, 4'd1);
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 4'hF, (c >= 6) ? 4'h1 : 4'h0, 4'd0, 4'd1, 4'd1);
      e = 4'h1 << (c % 4);
      chk($sformatf("ccd0 rd_gnt c%0d", c), int'(rd_gnt), int'(e));
      chk($sformatf("ccd0 onehot c%0d", c), int'($countones({rd_gnt, wr_gnt}) <= 1), 1);
    end

    // Reset during a long W2R: ccd (14) and turn (10) are dropped, read goes at once.
    step(1'b1, 4'h0, 4'h0, 4'd15, 4'd0, 4'd10);
    step(1'b0, 4'h0, 4'h1, 4'd15, 4'd0, 4'd10);
    step(1'b0, 4'h0, 4'h1, 4'd15, 4'd0, 4'd10);
    step(1'b0, 4'h0, 4'h1, 4'd15, 4'd0, 4'd10);
    chk("wtr setup wr_gnt", int'(wr_gnt), 1);
    step(1'b0, 4'h1, 4'h0, 4'd15, 4'd0, 4'd10);
    step(1'b0, 4'h1, 4'h0, 4'd15, 4'd0, 4'd10);
    chk("in W2R cur_dir", int'(cur_dir), 0);
    chk("in W2R rd_gnt", int'(rd_gnt), 0);
    step(1'b0, 4'h1, 4'h0, 4'd15, 4'd0, 4'd10);
    step(1'b1, 4'h1, 4'h0, 4'd15, 4'd0, 4'd10);
    chk("rst rd_gnt", int'(rd_gnt), 0);
    chk("rst cur_dir", int'(cur_dir), 0);
    step(1'b0, 4'h1, 4'h0, 4'd15, 4'd0, 4'd10);
    chk("post rst rd_gnt", int'(rd_gnt), 1);
    chk("post rst cur_dir", int'(cur_dir), 0);

`ifdef SAL_RW_SCHED_STAT_EN
    step(1'b1, 4'h0, 4'h0, 4'd0, 4'd0, 4'd0);
    chk("stat rst rd", int'(rd_gnt_cnt), 0);
    for (int c = 0; c < 70000; c++) step(1'b0, 4'hF, 4'h0, 4'd0, 4'd0, 4'd0);
    step(1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 4'd0);
    chk("stat rd_gnt_cnt", int'(rd_gnt_cnt), 4464);
    chk("stat wr_gnt_cnt", int'(wr_gnt_cnt), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
